// File: rtl/mem_access_unit.sv
// Load/store sequencer between execute and the 1 MiB RAM data port: one request at a time, IDLE -> ACCESS -> RESP.
// Optional misaligned-access trapping is compiled in with MEM_MISALIGN_TRAP_EN.
module mem_access_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_data,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_data,
  output logic [1:0]      mem_memo,
  output logic [7:0]      mem_mask,
  output logic            mem_en,
  input  logic [XLEN-1:0] mem_resp,
  input  logic            mem_exc,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_exc
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_r;
  logic              store_r;
  logic [1:0]        size_r;
  logic              unsigned_r;
  logic [XLEN-1:0]   addr_r;
  logic [XLEN-1:0]   data_r;
  logic [1:0]        memo_r;
  logic [7:0]        mask_r;
  logic              req_ready_r;
  logic              rsp_valid_r;
  logic [XLEN-1:0]   rsp_data_r;
  logic              rsp_exc_r;
  logic              misalign_s;
  logic              fault_s;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      2'b11:   size_mask = 8'hFF;
      default: size_mask = 8'h00;
    endcase
  endfunction

  function automatic logic [63:0] extend_load(input logic [63:0] raw, input logic [1:0] size,
                                              input logic uns);
    case (size)
      2'b00:   extend_load = {{56{~uns & raw[7]}},  raw[7:0]};
      2'b01:   extend_load = {{48{~uns & raw[15]}}, raw[15:0]};
      2'b10:   extend_load = {{32{~uns & raw[31]}}, raw[31:0]};
      2'b11:   extend_load = raw;
      default: extend_load = raw;
    endcase
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  // Natural-alignment check on the latched request.
  always_comb begin
    case (size_r)
      2'b00:   misalign_s = 1'b0;
      2'b01:   misalign_s = addr_r[0];
      2'b10:   misalign_s = |addr_r[1:0];
      2'b11:   misalign_s = |addr_r[2:0];
      default: misalign_s = 1'b0;
    endcase
  end
`else
  assign misalign_s = 1'b0;
`endif

  assign fault_s = mem_exc | misalign_s;

  // Write enable must follow mem_exc within the cycle and drop at once on reset.
  assign mem_en = (state_r == ACCESS) && store_r && !mem_exc && !misalign_s;

  assign req_ready = req_ready_r;
  assign mem_addr  = addr_r;
  assign mem_data  = data_r;
  assign mem_memo  = memo_r;
  assign mem_mask  = mask_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_exc   = rsp_exc_r;

  // Request sequencing FSM with registered RAM controls and response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      store_r     <= 1'b0;
      size_r      <= 2'b00;
      unsigned_r  <= 1'b0;
      addr_r      <= '0;
      data_r      <= '0;
      memo_r      <= 2'b00;
      mask_r      <= 8'h00;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= '0;
      rsp_exc_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            store_r     <= req_store;
            size_r      <= req_size;
            unsigned_r  <= req_unsigned;
            addr_r      <= req_addr;
            data_r      <= req_data;
            memo_r      <= req_store ? 2'b11 : 2'b01;
            mask_r      <= size_mask(req_size);
            req_ready_r <= 1'b0;
            state_r     <= ACCESS;
          end
        end
        ACCESS: begin
          memo_r      <= 2'b00;
          mask_r      <= 8'h00;
          rsp_exc_r   <= fault_s;
          rsp_data_r  <= (store_r || fault_s) ? '0 : extend_load(mem_resp, size_r, unsigned_r);
          rsp_valid_r <= 1'b1;
          state_r     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          memo_r      <= 2'b00;
          mask_r      <= 8'h00;
          rsp_valid_r <= 1'b0;
          req_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule
